// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS subset CPU: add/sub/and/or/slt, lw, sw, beq, addi.
// Define MIPS_JUMP_EN to decode j (op 02); otherwise op 02 is a NOP.
module mips_imem #(
   parameter int DEPTH = 256
) (
   input  logic [$clog2(DEPTH)-1:0] addr,
   output logic [31:0]              data
);
   logic [31:0] mem_array [0:DEPTH-1];

   assign data = mem_array[addr];
endmodule

module mips_dmem #(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);
   logic [31:0] mem_array [0:DEPTH-1];

   assign rdata = mem_array[addr];

   always_ff @(posedge clk) begin
      if (we) mem_array[addr] <= wdata;
   end
endmodule

module mips_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] mem [0:31];

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

   always_ff @(posedge clk) begin
      if (we && wa != 5'd0) mem[wa] <= wd;
   end
endmodule

module mips_single_cycle #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   output logic [31:0] pc_out
);
   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
   } alu_op_t;

   logic [31:0] pc, pc_next, pc_plus4, instr;
   logic [31:0] rs_val, rt_val, imm_se, alu_b, alu_y;
   logic [31:0] dmem_rdata, wb_data;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wa;
   logic        reg_we, mem_we, use_imm, mem_to_reg;
   logic        dst_rd, branch, jump, run;
   alu_op_t     alu_op;

   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign funct  = instr[5:0];
   assign imm_se = {{16{instr[15]}}, instr[15:0]};
   assign pc_out = pc;

   // Nothing architectural commits while the PC is being restarted.
   assign run = rst & ~clr;

   mips_imem #(.DEPTH(IMEM_DEPTH)) instructionmem (
      .addr (pc[IW+1:2]),
      .data (instr)
   );

   always_comb begin
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      use_imm    = 1'b0;
      mem_to_reg = 1'b0;
      dst_rd     = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      alu_op     = ALU_ADD;
      case (op)
         6'h00: begin
            dst_rd = 1'b1;
            reg_we = 1'b1;
            case (funct)
               6'h20:   alu_op = ALU_ADD;
               6'h22:   alu_op = ALU_SUB;
               6'h24:   alu_op = ALU_AND;
               6'h25:   alu_op = ALU_OR;
               6'h2A:   alu_op = ALU_SLT;
               default: reg_we = 1'b0;
            endcase
         end
         6'h23: begin
            reg_we     = 1'b1;
            use_imm    = 1'b1;
            mem_to_reg = 1'b1;
         end
         6'h2B: begin
            mem_we  = 1'b1;
            use_imm = 1'b1;
         end
         6'h04: begin
            branch = 1'b1;
            alu_op = ALU_SUB;
         end
         6'h08: begin
            reg_we  = 1'b1;
            use_imm = 1'b1;
         end
`ifdef MIPS_JUMP_EN
         6'h02: jump = 1'b1;
`endif
         default: ;
      endcase
   end

   mips_regfile registers (
      .clk (clk),
      .we  (reg_we & run),
      .ra1 (rs),
      .ra2 (rt),
      .wa  (wa),
      .wd  (wb_data),
      .rd1 (rs_val),
      .rd2 (rt_val)
   );

   assign wa    = dst_rd ? rd : rt;
   assign alu_b = use_imm ? imm_se : rt_val;

   always_comb begin
      alu_y = rs_val + alu_b;
      case (alu_op)
         ALU_SUB: alu_y = rs_val - alu_b;
         ALU_AND: alu_y = rs_val & alu_b;
         ALU_OR:  alu_y = rs_val | alu_b;
         ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
         default: alu_y = rs_val + alu_b;
      endcase
   end

   mips_dmem #(.DEPTH(DMEM_DEPTH)) datamem (
      .clk   (clk),
      .we    (mem_we & run),
      .addr  (alu_y[DW+1:2]),
      .wdata (rt_val),
      .rdata (dmem_rdata)
   );

   assign wb_data  = mem_to_reg ? dmem_rdata : alu_y;
   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      pc_next = pc_plus4;
      if (branch && alu_y == 32'd0)
         pc_next = pc_plus4 + {imm_se[29:0], 2'b00};
      else if (jump)
         pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (!rst)     pc <= 32'd0;
      else if (clr) pc <= 32'd0;
      else          pc <= pc_next;
   end

   logic unused_bits;
   assign unused_bits = ^{pc[31:IW+2], pc[1:0], instr[10:6],
                          alu_y[31:DW+2], alu_y[1:0]};
endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: directed program plus random programs
// checked against an instruction-level model of the ISA subset.
module tb_mips_single_cycle;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] pc_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_reg  [32];
   logic [31:0] m_imem [256];
   logic [31:0] m_dmem [256];
   logic [31:0] m_pc;
   int          w_reg;
   int          w_mem;

   mips_single_cycle dut (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .pc_out (pc_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void exec();
      logic [31:0] ins, a, b, se, npc, addr;
      int          rs, rt, rd;
      ins  = m_imem[m_pc[9:2]];
      rs   = int'(ins[25:21]);
      rt   = int'(ins[20:16]);
      rd   = int'(ins[15:11]);
      a    = m_reg[rs];
      b    = m_reg[rt];
      se   = {{16{ins[15]}}, ins[15:0]};
      addr = a + se;
      npc  = m_pc + 4;
      case (ins[31:26])
         6'h00: begin
            w_reg = rd;
            case (ins[5:0])
               6'h20: m_reg[rd] = a + b;
               6'h22: m_reg[rd] = a - b;
               6'h24: m_reg[rd] = a & b;
               6'h25: m_reg[rd] = a | b;
               6'h2A: m_reg[rd] = ($signed(a) < $signed(b)) ? 1 : 0;
               default: w_reg = -1;
            endcase
         end
         6'h23: begin
            m_reg[rt] = m_dmem[addr[9:2]];
            w_reg = rt;
         end
         6'h2B: begin
            m_dmem[addr[9:2]] = b;
            w_mem = int'(addr[9:2]);
         end
         6'h04: if (a == b) npc = m_pc + 4 + (se << 2);
         6'h08: begin
            m_reg[rt] = a + se;
            w_reg = rt;
         end
`ifdef MIPS_JUMP_EN
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
`endif
         default: ;
      endcase
      m_reg[0] = 32'd0;
      m_pc = npc;
   endfunction

   task automatic step(input logic c, input logic r);
      @(negedge clk);
      clr = c;
      rst = r;
      w_reg = -1;
      w_mem = -1;
      if (!r || c) m_pc = 32'd0;
      else exec();
      @(posedge clk);
      #1;
      check("pc", pc_out, m_pc);
      if (w_reg > 0)
         check($sformatf("reg%0d", w_reg),
               dut.registers.mem[w_reg], m_reg[w_reg]);
      if (w_mem >= 0)
         check($sformatf("dmem%0d", w_mem),
               dut.datamem.mem_array[w_mem], m_dmem[w_mem]);
   endtask

   task automatic load(input logic [31:0] r0);
      for (int i = 0; i < 32; i++) dut.registers.mem[i] = m_reg[i];
      dut.registers.mem[0] = r0;
      for (int i = 0; i < 256; i++) begin
         dut.instructionmem.mem_array[i] = m_imem[i];
         dut.datamem.mem_array[i] = m_dmem[i];
      end
   endtask

   task automatic check_all();
      for (int i = 1; i < 32; i++)
         check($sformatf("final_reg%0d", i), dut.registers.mem[i], m_reg[i]);
      for (int i = 0; i < 256; i++)
         check($sformatf("final_dmem%0d", i),
               dut.datamem.mem_array[i], m_dmem[i]);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fn [5];
      fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24;
      fn[3] = 6'h25; fn[4] = 6'h2A;
      rs  = 5'($urandom_range(0, 15));
      rt  = 5'($urandom_range(0, 15));
      rd  = 5'($urandom_range(0, 15));
      imm = 16'($urandom);
      case ($urandom_range(0, 11))
         0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, fn[$urandom_range(0, 4)]};
         3: return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
         4: return {6'h23, rs, rt, imm};
         5: return {6'h2B, rs, rt, imm};
         6: return {6'h04, rs, rt, 16'($urandom_range(0, 8)) - 16'd4};
         7: return {6'h04, rs, rs, 16'($urandom_range(0, 8)) - 16'd4};
         8, 9: return {6'h08, rs, rt, imm};
         10: return {6'h02, 26'($urandom_range(0, 255))};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) m_reg[i] = (i < 10) ? i : $urandom;
      m_reg[0] = 32'd0;
      for (int i = 0; i < 256; i++) begin
         m_imem[i] = 32'd0;
         m_dmem[i] = $urandom;
      end
      m_dmem[0]  = 32'h0000005A;
      m_imem[0]  = 32'h00441020;
      m_imem[1]  = 32'h8C080000;
      m_imem[2]  = 32'h11080003;
      m_imem[6]  = 32'hAC030004;
      m_imem[7]  = 32'h8C090004;
      m_imem[8]  = 32'h00430020;
      m_imem[9]  = 32'h00A63822;
      m_imem[10] = 32'h00E5382A;
      m_imem[11] = 32'h2007FFFF;
      m_imem[12] = 32'h10220001;
      m_imem[13] = 32'h1000FFFF;
      m_pc = 32'd0;
      load(32'd0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b1);
         if (i == 7) check("slt_r7", dut.registers.mem[7], 32'd1);
         if (i == 6) check("sub_r7", dut.registers.mem[7], 32'hFFFFFFFF);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      check("pc_hold", pc_out, 32'd52);
      check("add_r2", dut.registers.mem[2], 32'd6);
      check("lw_r8", dut.registers.mem[8], 32'h5A);
      check("lw_r9", dut.registers.mem[9], 32'd3);
      check("sw_dmem1", dut.datamem.mem_array[1], 32'd3);
      check("r0_zero", dut.registers.mem[0], 32'd0);
      check("addi_r7", dut.registers.mem[7], 32'hFFFFFFFF);
      check_all();

      m_imem[2] = 32'd0;
      dut.instructionmem.mem_array[2] = 32'd0;
      step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      check("pc_at_12", pc_out, 32'd12);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      check("pc_after_clr", pc_out, 32'd4);
      check_all();

      for (int p = 0; p < 2; p++) begin
         step(1'b0, 1'b0);
         for (int i = 0; i < 32; i++) m_reg[i] = $urandom;
         m_reg[0] = 32'd0;
         for (int i = 0; i < 256; i++) begin
            m_imem[i] = rand_instr();
            m_dmem[i] = $urandom;
         end
         load(32'hDEADBEEF);
         step(1'b0, 1'b0);
         for (int i = 0; i < 300; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 39) != 0);
         check_all();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
